// File: rtl/stdp_pkg.sv
// Shared types and default constants for the STDP weight updater.
package stdp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CALC = 2'd2,
        WR   = 2'd3
    } stdp_state_e;

    localparam int STDP_A_PLUS  = 64;
    localparam int STDP_A_MINUS = 48;
    localparam int STDP_W_MIN   = 0;
    localparam int STDP_W_MAX   = 524287;

endpackage

// File: rtl/stdp_sat_adder.sv
// Combinational STDP delta: amplitude shifted by dt, added to or subtracted from the weight,
// then clamped to [W_MIN, W_MAX].
module stdp_sat_adder
    import stdp_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int DT_WIDTH   = 4,
    parameter int A_PLUS     = STDP_A_PLUS,
    parameter int A_MINUS    = STDP_A_MINUS,
    parameter int W_MIN      = STDP_W_MIN,
    parameter int W_MAX      = STDP_W_MAX
) (
    input  logic signed [DATA_WIDTH-1:0] i_weight,
    input  logic                         i_ltp,
    input  logic        [DT_WIDTH-1:0]   i_dt,
    output logic signed [DATA_WIDTH-1:0] o_weight,
    output logic                         o_clamped
);

    // Two guard bits keep weight +/- delta free of wrap-around before the clamp.
    localparam int SW = DATA_WIDTH + 2;
    localparam logic signed [SW-1:0] LP_AMP_P = SW'(A_PLUS);
    localparam logic signed [SW-1:0] LP_AMP_M = SW'(A_MINUS);
    localparam logic signed [SW-1:0] LP_MIN   = SW'(W_MIN);
    localparam logic signed [SW-1:0] LP_MAX   = SW'(W_MAX);

    logic signed [SW-1:0] w_amp;
    logic signed [SW-1:0] w_delta;
    logic signed [SW-1:0] w_ext;
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_res;

    assign w_amp   = i_ltp ? LP_AMP_P : LP_AMP_M;
    assign w_delta = (32'(i_dt) >= 32'd32) ? '0 : (w_amp >> i_dt);
    assign w_ext   = {{2{i_weight[DATA_WIDTH-1]}}, i_weight};
    assign w_sum   = i_ltp ? (w_ext + w_delta) : (w_ext - w_delta);

    always_comb begin
        w_res     = w_sum;
        o_clamped = 1'b0;
        if (w_sum < LP_MIN) begin
            w_res     = LP_MIN;
            o_clamped = 1'b1;
        end else if (w_sum > LP_MAX) begin
            w_res     = LP_MAX;
            o_clamped = 1'b1;
        end
    end

    assign o_weight = w_res[DATA_WIDTH-1:0];

endmodule

// File: rtl/stdp_weight_updater.sv
// STDP read-modify-write weight updater: IDLE -> RD -> CALC -> WR, one update per 4 cycles.
// Define STDP_UPD_SAT_CNT_EN to add the 16-bit saturating clamp-event counter sat_cnt.
module stdp_weight_updater
    import stdp_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 4,
    parameter int DT_WIDTH   = 4,
    parameter int A_PLUS     = STDP_A_PLUS,
    parameter int A_MINUS    = STDP_A_MINUS,
    parameter int W_MIN      = STDP_W_MIN,
    parameter int W_MAX      = STDP_W_MAX
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  logic        [ADDR_WIDTH-1:0] upd_addr,
    input  logic                         upd_ltp,
    input  logic        [DT_WIDTH-1:0]   upd_dt,
    output logic        [ADDR_WIDTH-1:0] Read_addr,
    output logic        [ADDR_WIDTH-1:0] Write_addr,
    output logic signed [DATA_WIDTH-1:0] Data_In,
    output logic                         we,
    input  logic signed [DATA_WIDTH-1:0] Data_out,
    output logic                         done
`ifdef STDP_UPD_SAT_CNT_EN
    ,
    output logic        [15:0]           sat_cnt
`endif
);

    stdp_state_e                  r_state;
    logic        [ADDR_WIDTH-1:0] r_read_addr;
    logic        [ADDR_WIDTH-1:0] r_write_addr;
    logic                         r_ltp;
    logic        [DT_WIDTH-1:0]   r_dt;
    logic signed [DATA_WIDTH-1:0] r_data_in;
    logic                         r_we;
    logic                         r_done;
    logic signed [DATA_WIDTH-1:0] w_new_weight;
    logic                         w_clamped;

    stdp_sat_adder #(
        .DATA_WIDTH (DATA_WIDTH),
        .DT_WIDTH   (DT_WIDTH),
        .A_PLUS     (A_PLUS),
        .A_MINUS    (A_MINUS),
        .W_MIN      (W_MIN),
        .W_MAX      (W_MAX)
    ) u_sat_adder (
        .i_weight  (Data_out),
        .i_ltp     (r_ltp),
        .i_dt      (r_dt),
        .o_weight  (w_new_weight),
        .o_clamped (w_clamped)
    );

`ifdef STDP_UPD_SAT_CNT_EN
    logic        r_clamped;
    logic [15:0] r_sat_cnt;
`else
    logic w_unused_clamped;
    assign w_unused_clamped = w_clamped;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_read_addr  <= '0;
            r_write_addr <= '0;
            r_ltp        <= 1'b0;
            r_dt         <= '0;
            r_data_in    <= '0;
            r_we         <= 1'b0;
            r_done       <= 1'b0;
`ifdef STDP_UPD_SAT_CNT_EN
            r_clamped    <= 1'b0;
            r_sat_cnt    <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (upd_valid) begin
                        r_read_addr <= upd_addr;
                        r_ltp       <= upd_ltp;
                        r_dt        <= upd_dt;
                        r_state     <= RD;
                    end
                end
                RD: begin
                    r_state <= CALC;
                end
                CALC: begin
                    // Data_out now holds the word addressed during RD.
                    r_data_in    <= w_new_weight;
                    r_write_addr <= r_read_addr;
                    r_we         <= 1'b1;
                    r_done       <= 1'b1;
                    r_state      <= WR;
`ifdef STDP_UPD_SAT_CNT_EN
                    r_clamped    <= w_clamped;
`endif
                end
                WR: begin
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
`ifdef STDP_UPD_SAT_CNT_EN
                    if (r_clamped && (r_sat_cnt != 16'hFFFF)) begin
                        r_sat_cnt <= r_sat_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign upd_ready  = (r_state == IDLE) && rst;
    assign Read_addr  = r_read_addr;
    assign Write_addr = r_write_addr;
    assign Data_In    = r_data_in;
    assign we         = r_we;
    assign done       = r_done;
`ifdef STDP_UPD_SAT_CNT_EN
    assign sat_cnt    = r_sat_cnt;
`endif

endmodule

// File: tb/tb_stdp_weight_updater.sv
// Scoreboard bench for stdp_weight_updater with a behavioural 1-cycle-latency weight RAM.
`timescale 1ns/1ps
module tb_stdp_weight_updater;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               upd_valid = 1'b0;
    logic               upd_ready;
    logic        [3:0]  upd_addr = '0;
    logic               upd_ltp = 1'b0;
    logic        [3:0]  upd_dt = '0;
    logic        [3:0]  Read_addr;
    logic        [3:0]  Write_addr;
    logic signed [19:0] Data_In;
    logic               we;
    logic signed [19:0] Data_out;
    logic               done;
`ifdef STDP_UPD_SAT_CNT_EN
    logic        [15:0] sat_cnt;
`endif

    stdp_weight_updater dut (
        .clk        (clk),
        .rst        (rst),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_addr   (upd_addr),
        .upd_ltp    (upd_ltp),
        .upd_dt     (upd_dt),
        .Read_addr  (Read_addr),
        .Write_addr (Write_addr),
        .Data_In    (Data_In),
        .we         (we),
        .Data_out   (Data_out),
        .done       (done)
`ifdef STDP_UPD_SAT_CNT_EN
        ,
        .sat_cnt    (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic signed [19:0] mem [16];
    always @(posedge clk) begin
        Data_out <= mem[Read_addr];
        if (we) mem[Write_addr] <= Data_In;
    end

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int n_we    = 0;
    int n_done  = 0;
    int acc_q [$];

    typedef struct {
        logic [3:0]         addr;
        logic signed [19:0] exp;
        int                 acc;
    } item_t;
    item_t sb_q [$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [19:0] model(input logic signed [19:0] w, input logic ltp,
                                                 input int dt);
        longint d;
        longint s;
        d = ltp ? 64 : 48;
        d = (dt >= 32) ? 0 : (d >> dt);
        s = ltp ? (longint'(w) + d) : (longint'(w) - d);
        if (s < 0) s = 0;
        if (s > 524287) s = 524287;
        return 20'(s);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        item_t it;
        if (rst) begin
            if (upd_valid && upd_ready) begin
                it.addr = upd_addr;
                it.exp  = model(mem[upd_addr], upd_ltp, int'(upd_dt));
                it.acc  = cyc + 1;
                sb_q.push_back(it);
                acc_q.push_back(cyc + 1);
            end
            if (done) n_done++;
            if (done && !we) check("done_without_we", 1, 0);
            if (we) begin
                n_we++;
                check("done_with_we", done, 1);
                if (sb_q.size() == 0) begin
                    check("we_unexpected", 1, 0);
                end else begin
                    it = sb_q.pop_front();
                    check("wr_addr", Write_addr, it.addr);
                    check("wr_data", Data_In, it.exp);
                    check("wr_cycle_E3", cyc, it.acc + 2);
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(upd_ready && sb_q.size() == 0) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 50) check("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_update(input logic [3:0] a, input logic ltp, input logic [3:0] dt);
        upd_addr  = a;
        upd_ltp   = ltp;
        upd_dt    = dt;
        upd_valid = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        int we0;
        int d0;
        int a0;
        int k;
        for (int i = 0; i < 16; i++) mem[i] = 20'sd0;

        #2;
        check("rst_ready", upd_ready, 0);
        check("rst_we", we, 0);
        check("rst_done", done, 0);
        check("rst_rd_addr", Read_addr, 0);
        check("rst_wr_addr", Write_addr, 0);
        check("rst_data_in", Data_In, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("ready_after_rst", upd_ready, 1);
        @(posedge clk); #1;

        mem[3] = 20'sd100;
        we0 = n_we;
        do_update(4'd3, 1'b1, 4'd0);
        check("mem3_ltp", mem[3], 164);
        check("mem3_one_we", n_we - we0, 1);

        mem[5] = 20'sd100;
        do_update(4'd5, 1'b0, 4'd2);
        check("mem5_ltd", mem[5], 88);

        mem[7] = 20'sd524280;
        do_update(4'd7, 1'b1, 4'd0);
        check("mem7_clamp_hi", mem[7], 524287);
`ifdef STDP_UPD_SAT_CNT_EN
        check("sat_cnt_1", sat_cnt, 1);
`endif

        mem[2] = 20'sd10;
        do_update(4'd2, 1'b0, 4'd0);
        check("mem2_clamp_lo", mem[2], 0);
`ifdef STDP_UPD_SAT_CNT_EN
        check("sat_cnt_2", sat_cnt, 2);
`endif

        mem[9] = 20'sd77;
        we0 = n_we;
        do_update(4'd9, 1'b1, 4'd15);
        check("mem9_zero_delta", mem[9], 77);
        check("mem9_write_occurs", n_we - we0, 1);

        // Valid held high across three back-to-back updates to the same word.
        mem[1] = 20'sd0;
        d0 = n_done;
        a0 = acc_q.size();
        upd_addr  = 4'd1;
        upd_ltp   = 1'b1;
        upd_dt    = 4'd1;
        upd_valid = 1'b1;
        k = 0;
        while (acc_q.size() < a0 + 3 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        upd_valid = 1'b0;
        if (k >= 40) check("b2b_timeout", 0, 1);
        wait_idle();
        check("b2b_done_count", n_done - d0, 3);
        check("b2b_accepts", acc_q.size() - a0, 3);
        if (acc_q.size() >= a0 + 3) begin
            check("b2b_gap_1", acc_q[a0 + 1] - acc_q[a0], 4);
            check("b2b_gap_2", acc_q[a0 + 2] - acc_q[a0 + 1], 4);
        end
        check("mem1_chain", mem[1], 96);

        // Reset while the update is in CALC.
        mem[11] = 20'sd500;
        we0 = n_we;
        d0  = n_done;
        upd_addr  = 4'd11;
        upd_ltp   = 1'b1;
        upd_dt    = 4'd0;
        upd_valid = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_ready", upd_ready, 0);
        check("abort_we", we, 0);
        check("abort_done", done, 0);
        check("abort_rd_addr", Read_addr, 0);
        check("abort_data_in", Data_In, 0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", upd_ready, 1);
        repeat (8) @(posedge clk);
        #1;
        check("abort_mem_unchanged", mem[11], 500);
        check("abort_no_we", n_we - we0, 0);
        check("abort_no_done", n_done - d0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
